store_txn_ctrl_gen: RTL and testbench
=====================================

# store_txn_ctrl_gen

Store-side transaction generator for the VLSU. It takes one unit-stride store request (byte address and byte count) and splits it into AXI4 INCR bursts that respect 4 KiB boundaries and the maximum burst length. It issues one AW per burst and a per-beat `txn_ctrl_t` stream to the sequential store data controller, which uses that stream to pack nibbles into W beats.

## Interface
Parameters:
- `AxiDataWidth`, 128: W bus width in bits; `busBytes = AxiDataWidth/8`, `busNibbles = 2*busBytes`.
- `AxiAddrWidth`, 64: address width.
- `AxiIdWidth`, 4: AW ID width.
- `AxiId`, 0: constant AW ID driven on every burst.
- `MaxBurstLen`, 256: maximum beats per burst (1..256).
- `ReqLenWidth`, 32: width of request byte count.

Ports:
- Clock and reset: reset `rst_ni`, asynchronous, active-low; clock `clk_i`.
- `req_valid_i`, in, 1: store request valid.
- `req_ready_o`, out, 1: request accepted.
- `req_addr_i`, in, AxiAddrWidth: start byte address.
- `req_nr_bytes_i`, in, ReqLenWidth: total bytes.
- `aw_valid_o`, out, 1: AW valid.
- `aw_ready_i`, in, 1: AW ready.
- `aw_addr_o`, out, AxiAddrWidth: burst start byte address (unaligned allowed).
- `aw_len_o`, out, 8: beats−1.
- `aw_size_o`, out, 3: `$clog2(busBytes)`.
- `aw_burst_o`, out, 2: INCR (2'b01).
- `aw_id_o`, out, AxiIdWidth: `AxiId`.
- `txn_ctrl_valid_o`, out, 1: per-beat control valid.
- `txn_ctrl_ready_i`, in, 1: consumer finished this beat.
- `txn_ctrl_o`, out, `txn_ctrl_t`: per-beat control fields `addr`, `isHead`, `rmnBeat`, `lbN`, `isFinalTxn`.

## Operation
- FSM states:
  - `S_IDLE`: `req_ready_o = 1`. On handshake, latch `cur_addr = req_addr_i` and `rmn_bytes = req_nr_bytes_i`. A zero byte count is accepted and dropped, and the FSM stays in `S_IDLE`. Otherwise go to `S_AW`.
  - `S_AW`: compute the split combinationally from registered `cur_addr` and `rmn_bytes`.
    - `off = cur_addr mod busBytes`.
    - `lim4k = 4096 − cur_addr[11:0]`.
    - `limBL = MaxBurstLen*busBytes − off`.
    - `txn_bytes = min(rmn_bytes, lim4k, limBL)`.
    - `beats = ceil((off + txn_bytes)/busBytes)`.
    - `aw_valid_o = 1` with `aw_len_o = beats−1`.
    - On AW handshake, latch `beats`, `txn_bytes`, `lbN = (((off+txn_bytes−1) mod busBytes)+1)*2`, and `isFinalTxn = (rmn_bytes == txn_bytes)`. Set beat counter `rmn_beat = beats−1`, then go to `S_BEATS`.
  - `S_BEATS`: `txn_ctrl_valid_o = 1`.
    - `txn_ctrl_o.addr` is the burst start address.
    - `isHead = 1` only on the first beat of the burst.
    - `rmnBeat` is the current counter value.
    - `lbN` and `isFinalTxn` are the latched values.
    - On handshake with `rmnBeat != 0`, decrement the counter.
    - On handshake with `rmnBeat == 0`: advance `cur_addr += txn_bytes` and `rmn_bytes −= txn_bytes`. Go to `S_IDLE` if `isFinalTxn`, else `S_AW`.
- Field meaning for `txn_ctrl_o.addr`: its low `busNSize` bits are the start nibble offset within the beat, `2*off`. The AW address itself stays a byte address.
- All `txn_ctrl_o` fields are held stable while `valid && !ready`. AW fields are held stable while `aw_valid_o && !aw_ready_i`.
- Arithmetic widths: `lim4k` uses 13 bits; `txn_bytes` uses ReqLenWidth bits; `beats` uses 9 bits (max 256); `lbN` uses `busNSize+1` bits, range 1..busNibbles.

## Timing
- Reset values: FSM `S_IDLE`; `req_ready_o = 1`, `aw_valid_o = 0`, `txn_ctrl_valid_o = 0`; all registered fields 0.
- Request handshake at cycle t puts `aw_valid_o` high at t+1.
- AW handshake at t puts `txn_ctrl_valid_o` high at t+1.
- Consecutive beats stream at 1 per cycle with ready held high.
- Burst-to-burst costs one cycle in `S_AW` plus the AW handshake.
- Request-to-request costs one `S_IDLE` cycle.
- No AW for burst k+1 is issued before the last beat of burst k is handshaken.
- An asynchronous reset mid-burst drops all state immediately, and outputs return to their reset values. Any partially emitted burst is abandoned, and system-level reset covers the consumer.

## Structure
- `txn_ctrl_t` lives in `vlsu_pkg` and is shared with the store data controller.
- A `vlsu_pkg` function `calc_store_split(addr, rmn_bytes)` returns `{beats, txn_bytes, lbN}` so load-side generators can reuse it.
- Single module, no sub-modules; 2-state registers plus counters, about 200 lines.

## Test plan
All scenarios use `AxiDataWidth = 128` (busBytes = 16).

- **Single unaligned burst:** `addr = 0x1004`, 40 B → one AW with `addr = 0x1004`, `len = 2`. Three beats with `rmnBeat` 2, 1, 0; `isHead` only on the first; `lbN = 24`; `isFinalTxn = 1`; `txn_ctrl.addr[4:0] = 8`.
- **4 KiB split:** `addr = 0x0FF8`, 32 B → AW0 `0x0FF8`, `len = 0`, `lbN = 32`, `isFinalTxn = 0`; then AW1 `0x1000`, `len = 1`, `lbN = 16`, `isFinalTxn = 1`.
- **Max burst:** `addr = 0`, 8192 B → two AWs at `0x0` and `0x1000`, each `len = 255`, 512 beats total, last `lbN = 32`.
- **Backpressure:** random `aw_ready_i` and `txn_ctrl_ready_i` stalls → outputs stay stable while stalled, and beat count and order are unchanged.
- **Zero length:** `nr_bytes = 0` → `req_ready_o` handshakes, no AW and no txn_ctrl are emitted, and the next request is accepted one cycle later.
- **Reset mid-burst:** assert `rst_ni = 0` during beat 1 of 3 → `aw_valid_o`, `txn_ctrl_valid_o = 0` and `req_ready_o = 1` immediately; a new request after reset starts cleanly with `isHead = 1`.

Source files
------------

// File: rtl/vlsu_pkg.sv
`default_nettype none
// Shared VLSU types: per-beat store control record and the burst-split helper
// used by the store (and load) transaction generators.
package vlsu_pkg;

    localparam int unsigned VlsuAxiDataWidth = 128;
    localparam int unsigned VlsuAxiAddrWidth = 64;
    localparam int unsigned VlsuReqLenWidth  = 32;
    localparam int unsigned BusBytes         = VlsuAxiDataWidth / 8;
    localparam int unsigned BusNibbles       = 2 * BusBytes;
    localparam int unsigned BusSize          = $clog2(BusBytes);
    localparam int unsigned BusNSize         = $clog2(BusNibbles);

    typedef struct packed {
        logic [VlsuAxiAddrWidth-1:0] addr;
        logic                        isHead;
        logic [7:0]                  rmnBeat;
        logic [BusNSize:0]           lbN;
        logic                        isFinalTxn;
    } txn_ctrl_t;

    typedef struct packed {
        logic [8:0]                 beats;
        logic [VlsuReqLenWidth-1:0] txn_bytes;
        logic [BusNSize:0]          lbN;
    } store_split_t;

    // Largest burst starting at addr that stays inside one 4 KiB page and
    // within max_burst_len beats; lbN counts valid nibbles in the last beat.
    function automatic store_split_t calc_store_split(
        input logic [VlsuAxiAddrWidth-1:0] addr,
        input logic [VlsuReqLenWidth-1:0]  rmn_bytes,
        input int unsigned                 max_burst_len = 256
    );
        logic [BusSize-1:0]         off;
        logic [12:0]                lim4k;
        logic [VlsuReqLenWidth-1:0] lim_bl;
        logic [VlsuReqLenWidth-1:0] txn;
        logic [VlsuReqLenWidth:0]   span;
        logic [BusSize:0]           last_bytes;
        store_split_t               res;
        off    = addr[BusSize-1:0];
        lim4k  = 13'd4096 - {1'b0, addr[11:0]};
        lim_bl = VlsuReqLenWidth'(max_burst_len * BusBytes) - VlsuReqLenWidth'(off);
        txn    = rmn_bytes;
        if (VlsuReqLenWidth'(lim4k) < txn) txn = VlsuReqLenWidth'(lim4k);
        if (lim_bl < txn) txn = lim_bl;
        span       = {1'b0, txn} + (VlsuReqLenWidth+1)'(off);
        last_bytes = {1'b0, BusSize'(span[BusSize-1:0] - BusSize'(1))} + (BusSize+1)'(1);
        res.beats     = 9'((span + (VlsuReqLenWidth+1)'(BusBytes - 1)) >> BusSize);
        res.txn_bytes = txn;
        res.lbN       = {last_bytes, 1'b0};
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_txn_ctrl_gen.sv
`default_nettype none
// Splits one unit-stride store request into AXI4 INCR bursts (one AW each)
// and a per-beat txn_ctrl_t stream for the store data packer.
module store_txn_ctrl_gen
    import vlsu_pkg::*;
#(
    parameter int unsigned           AxiDataWidth = VlsuAxiDataWidth,
    parameter int unsigned           AxiAddrWidth = VlsuAxiAddrWidth,
    parameter int unsigned           AxiIdWidth   = 4,
    parameter logic [AxiIdWidth-1:0] AxiId        = '0,
    parameter int unsigned           MaxBurstLen  = 256,
    parameter int unsigned           ReqLenWidth  = VlsuReqLenWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic [ReqLenWidth-1:0]  req_nr_bytes_i,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [AxiAddrWidth-1:0] aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic [AxiIdWidth-1:0]   aw_id_o,
    output logic                    txn_ctrl_valid_o,
    input  logic                    txn_ctrl_ready_i,
    output txn_ctrl_t               txn_ctrl_o
);

    localparam int unsigned BusSizeLocal = $clog2(AxiDataWidth / 8);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AW    = 2'd1,
        S_BEATS = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [AxiAddrWidth-1:0] cur_addr, cur_addr_nxt;
    logic [ReqLenWidth-1:0]  rmn_bytes, rmn_bytes_nxt;
    logic [ReqLenWidth-1:0]  txn_bytes, txn_bytes_nxt;
    logic [8:0]              beats, beats_nxt;
    logic [7:0]              rmn_beat, rmn_beat_nxt;
    logic [BusNSize:0]       lbn, lbn_nxt;
    logic                    is_final, is_final_nxt;
    store_split_t            split;

    assign split = calc_store_split(VlsuAxiAddrWidth'(cur_addr),
                                    VlsuReqLenWidth'(rmn_bytes), MaxBurstLen);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            rmn_bytes <= '0;
            txn_bytes <= '0;
            beats     <= '0;
            rmn_beat  <= '0;
            lbn       <= '0;
            is_final  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            rmn_bytes <= rmn_bytes_nxt;
            txn_bytes <= txn_bytes_nxt;
            beats     <= beats_nxt;
            rmn_beat  <= rmn_beat_nxt;
            lbn       <= lbn_nxt;
            is_final  <= is_final_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cur_addr_nxt     = cur_addr;
        rmn_bytes_nxt    = rmn_bytes;
        txn_bytes_nxt    = txn_bytes;
        beats_nxt        = beats;
        rmn_beat_nxt     = rmn_beat;
        lbn_nxt          = lbn;
        is_final_nxt     = is_final;
        req_ready_o      = 1'b0;
        aw_valid_o       = 1'b0;
        txn_ctrl_valid_o = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    cur_addr_nxt  = req_addr_i;
                    rmn_bytes_nxt = req_nr_bytes_i;
                    // Empty requests are consumed without producing a burst.
                    if (req_nr_bytes_i != '0) state_nxt = S_AW;
                end
            end
            S_AW: begin
                aw_valid_o = 1'b1;
                if (aw_ready_i) begin
                    beats_nxt     = split.beats;
                    txn_bytes_nxt = ReqLenWidth'(split.txn_bytes);
                    lbn_nxt       = split.lbN;
                    is_final_nxt  = (rmn_bytes == ReqLenWidth'(split.txn_bytes));
                    rmn_beat_nxt  = 8'(split.beats - 9'd1);
                    state_nxt     = S_BEATS;
                end
            end
            S_BEATS: begin
                txn_ctrl_valid_o = 1'b1;
                if (txn_ctrl_ready_i) begin
                    if (rmn_beat != 8'd0) begin
                        rmn_beat_nxt = rmn_beat - 8'd1;
                    end else begin
                        cur_addr_nxt  = cur_addr + AxiAddrWidth'(txn_bytes);
                        rmn_bytes_nxt = rmn_bytes - txn_bytes;
                        state_nxt     = is_final ? S_IDLE : S_AW;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign aw_addr_o  = cur_addr;
    assign aw_len_o   = 8'(split.beats - 9'd1);
    assign aw_size_o  = 3'(BusSizeLocal);
    assign aw_burst_o = 2'b01;
    assign aw_id_o    = AxiId;

    // Nibble address: low bits give the start nibble offset inside the beat.
    assign txn_ctrl_o.addr       = VlsuAxiAddrWidth'({cur_addr, 1'b0});
    assign txn_ctrl_o.isHead     = ({1'b0, rmn_beat} == (beats - 9'd1));
    assign txn_ctrl_o.rmnBeat    = rmn_beat;
    assign txn_ctrl_o.lbN        = lbn;
    assign txn_ctrl_o.isFinalTxn = is_final;

endmodule
`default_nettype wire

// File: tb/tb_store_txn_ctrl_gen.sv
`default_nettype none
// Directed bench for store_txn_ctrl_gen with 128-bit bus (16 B per beat).
module tb_store_txn_ctrl_gen;
    import vlsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [31:0] req_nr_bytes = '0;
    logic        aw_valid;
    logic        aw_ready = 1'b0;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_id;
    logic        txn_valid;
    logic        txn_ready = 1'b0;
    txn_ctrl_t   txn_ctrl;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  id;
    } aw_rec_t;

    aw_rec_t   aw_q[$];
    int        aw_cyc[$];
    txn_ctrl_t beat_q[$];
    int        beat_cyc[$];
    int        unstable;
    bit        timed_out;
    bit        req_seen_ready;

    always #5 clk = ~clk;

    store_txn_ctrl_gen dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_addr_i       (req_addr),
        .req_nr_bytes_i   (req_nr_bytes),
        .aw_valid_o       (aw_valid),
        .aw_ready_i       (aw_ready),
        .aw_addr_o        (aw_addr),
        .aw_len_o         (aw_len),
        .aw_size_o        (aw_size),
        .aw_burst_o       (aw_burst),
        .aw_id_o          (aw_id),
        .txn_ctrl_valid_o (txn_valid),
        .txn_ctrl_ready_i (txn_ready),
        .txn_ctrl_o       (txn_ctrl)
    );

    // Stimulus/recorder only: issues one request and logs every AW and beat
    // handshake with its cycle index (cycle 1 = first cycle after acceptance).
    task automatic run_req(input logic [63:0] a, input logic [31:0] n,
                           input int stall_pct, input int budget);
        bit        done;
        bit        hold_aw;
        bit        hold_w;
        int        cyc;
        aw_rec_t   prev_aw;
        txn_ctrl_t prev_w;
        aw_rec_t   cur_aw;
        aw_q.delete(); aw_cyc.delete(); beat_q.delete(); beat_cyc.delete();
        unstable = 0; timed_out = 1'b0; done = 1'b0; hold_aw = 1'b0; hold_w = 1'b0;
        prev_aw = '{default: '0}; prev_w = '0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_nr_bytes = n;
        req_seen_ready = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!done) begin
            if (cyc > budget) begin
                timed_out = 1'b1;
                break;
            end
            aw_ready  = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            txn_ready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
            cur_aw = '{addr: aw_addr, len: aw_len, size: aw_size, burst: aw_burst, id: aw_id};
            if (hold_aw && (!aw_valid || cur_aw != prev_aw)) unstable++;
            if (hold_w && (!txn_valid || txn_ctrl !== prev_w)) unstable++;
            hold_aw = aw_valid && !aw_ready;
            hold_w  = txn_valid && !txn_ready;
            prev_aw = cur_aw;
            prev_w  = txn_ctrl;
            if (aw_valid && aw_ready) begin
                aw_q.push_back(cur_aw);
                aw_cyc.push_back(cyc);
            end
            if (txn_valid && txn_ready) begin
                beat_q.push_back(txn_ctrl);
                beat_cyc.push_back(cyc);
                if (txn_ctrl.isFinalTxn && txn_ctrl.rmnBeat == 8'd0) done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        aw_ready = 1'b0; txn_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_vec++; if (aw_valid !== 1'b0) begin n_err++; $display("FAIL reset_aw_valid got %b want 0", aw_valid); end
        n_vec++; if (txn_valid !== 1'b0) begin n_err++; $display("FAIL reset_txn_valid got %b want 0", txn_valid); end
        n_vec++; if (txn_ctrl !== txn_ctrl_t'('0)) begin n_err++; $display("FAIL reset_txn_ctrl got %h want 0", txn_ctrl); end
        rst_ni = 1'b1;
    endtask

    task automatic test_single_unaligned();
        run_req(64'h1004, 32'd40, 0, 50);
        n_vec++; if (timed_out || !req_seen_ready) begin n_err++; $display("FAIL single_done timeout=%b ready=%b want 0/1", timed_out, req_seen_ready); end
        n_vec++; if (aw_q.size() !== 1) begin n_err++; $display("FAIL single_aw_count got %0d want 1", aw_q.size()); end
        if (aw_q.size() >= 1) begin
            n_vec++; if (aw_q[0].addr !== 64'h1004 || aw_q[0].len !== 8'd2) begin n_err++; $display("FAIL single_aw addr=%h len=%0d want 1004/2", aw_q[0].addr, aw_q[0].len); end
            n_vec++; if (aw_q[0].size !== 3'd4 || aw_q[0].burst !== 2'b01 || aw_q[0].id !== 4'd0) begin n_err++; $display("FAIL single_aw_attr size=%0d burst=%0d id=%0d want 4/1/0", aw_q[0].size, aw_q[0].burst, aw_q[0].id); end
            n_vec++; if (aw_cyc[0] !== 1) begin n_err++; $display("FAIL single_aw_latency got %0d want 1", aw_cyc[0]); end
        end
        n_vec++; if (beat_q.size() !== 3) begin n_err++; $display("FAIL single_beat_count got %0d want 3", beat_q.size()); end
        for (int i = 0; i < beat_q.size(); i++) begin
            n_vec++;
            if (beat_q[i].rmnBeat !== 8'(2 - i) || beat_q[i].isHead !== (i == 0) || beat_q[i].lbN !== 6'd24
                || beat_q[i].isFinalTxn !== 1'b1 || beat_q[i].addr[4:0] !== 5'd8 || beat_cyc[i] !== 2 + i) begin
                n_err++;
                $display("FAIL single_beat%0d rmn=%0d head=%b lbN=%0d fin=%b nib=%0d cyc=%0d want %0d/%b/24/1/8/%0d",
                         i, beat_q[i].rmnBeat, beat_q[i].isHead, beat_q[i].lbN, beat_q[i].isFinalTxn,
                         beat_q[i].addr[4:0], beat_cyc[i], 2 - i, (i == 0), 2 + i);
            end
        end
        n_vec++; if (req_ready !== 1'b1 || aw_valid !== 1'b0) begin n_err++; $display("FAIL single_back_idle ready=%b awv=%b want 1/0", req_ready, aw_valid); end
    endtask

    task automatic test_4k_split();
        run_req(64'h0FF8, 32'd32, 0, 50);
        n_vec++; if (timed_out || aw_q.size() !== 2 || beat_q.size() !== 3) begin n_err++; $display("FAIL split_counts timeout=%b aw=%0d beats=%0d want 0/2/3", timed_out, aw_q.size(), beat_q.size()); end
        if (aw_q.size() == 2 && beat_q.size() == 3) begin
            n_vec++; if (aw_q[0].addr !== 64'h0FF8 || aw_q[0].len !== 8'd0) begin n_err++; $display("FAIL split_aw0 addr=%h len=%0d want ff8/0", aw_q[0].addr, aw_q[0].len); end
            n_vec++; if (aw_q[1].addr !== 64'h1000 || aw_q[1].len !== 8'd1) begin n_err++; $display("FAIL split_aw1 addr=%h len=%0d want 1000/1", aw_q[1].addr, aw_q[1].len); end
            n_vec++; if (aw_cyc[1] !== 3) begin n_err++; $display("FAIL split_aw1_cycle got %0d want 3", aw_cyc[1]); end
            n_vec++; if (beat_q[0].lbN !== 6'd32 || beat_q[0].isFinalTxn !== 1'b0 || beat_q[0].isHead !== 1'b1 || beat_q[0].addr[4:0] !== 5'd16) begin n_err++; $display("FAIL split_beat0 lbN=%0d fin=%b head=%b nib=%0d want 32/0/1/16", beat_q[0].lbN, beat_q[0].isFinalTxn, beat_q[0].isHead, beat_q[0].addr[4:0]); end
            n_vec++; if (beat_q[1].lbN !== 6'd16 || beat_q[1].isFinalTxn !== 1'b1 || beat_q[1].isHead !== 1'b1 || beat_q[1].rmnBeat !== 8'd1 || beat_q[1].addr[4:0] !== 5'd0) begin n_err++; $display("FAIL split_beat1 lbN=%0d fin=%b head=%b rmn=%0d want 16/1/1/1", beat_q[1].lbN, beat_q[1].isFinalTxn, beat_q[1].isHead, beat_q[1].rmnBeat); end
            n_vec++; if (beat_q[2].isHead !== 1'b0 || beat_q[2].rmnBeat !== 8'd0 || beat_q[2].lbN !== 6'd16) begin n_err++; $display("FAIL split_beat2 head=%b rmn=%0d lbN=%0d want 0/0/16", beat_q[2].isHead, beat_q[2].rmnBeat, beat_q[2].lbN); end
        end
    endtask

    task automatic test_max_burst();
        run_req(64'h0, 32'd8192, 0, 700);
        n_vec++; if (timed_out || aw_q.size() !== 2 || beat_q.size() !== 512) begin n_err++; $display("FAIL max_counts timeout=%b aw=%0d beats=%0d want 0/2/512", timed_out, aw_q.size(), beat_q.size()); end
        if (aw_q.size() == 2 && beat_q.size() == 512) begin
            n_vec++; if (aw_q[0].addr !== 64'h0 || aw_q[0].len !== 8'd255 || aw_q[1].addr !== 64'h1000 || aw_q[1].len !== 8'd255) begin n_err++; $display("FAIL max_aw a0=%h l0=%0d a1=%h l1=%0d want 0/255/1000/255", aw_q[0].addr, aw_q[0].len, aw_q[1].addr, aw_q[1].len); end
            n_vec++; if (beat_q[255].rmnBeat !== 8'd0 || beat_q[255].isFinalTxn !== 1'b0 || beat_q[256].isHead !== 1'b1 || beat_q[256].rmnBeat !== 8'd255) begin n_err++; $display("FAIL max_boundary rmn255=%0d fin255=%b head256=%b rmn256=%0d want 0/0/1/255", beat_q[255].rmnBeat, beat_q[255].isFinalTxn, beat_q[256].isHead, beat_q[256].rmnBeat); end
            n_vec++; if (beat_q[511].lbN !== 6'd32 || beat_q[511].isFinalTxn !== 1'b1) begin n_err++; $display("FAIL max_last lbN=%0d fin=%b want 32/1", beat_q[511].lbN, beat_q[511].isFinalTxn); end
        end
    endtask

    // 0x1F3C, 300 B: 196 B to the page end (13 beats, lbN 32) then 104 B (7 beats, lbN 16).
    task automatic test_backpressure();
        int heads;
        run_req(64'h1F3C, 32'd300, 40, 400);
        n_vec++; if (timed_out || unstable !== 0) begin n_err++; $display("FAIL bp_stable timeout=%b unstable=%0d want 0/0", timed_out, unstable); end
        n_vec++; if (aw_q.size() !== 2 || beat_q.size() !== 20) begin n_err++; $display("FAIL bp_counts aw=%0d beats=%0d want 2/20", aw_q.size(), beat_q.size()); end
        if (aw_q.size() == 2 && beat_q.size() == 20) begin
            n_vec++; if (aw_q[0].addr !== 64'h1F3C || aw_q[0].len !== 8'd12 || aw_q[1].addr !== 64'h2000 || aw_q[1].len !== 8'd6) begin n_err++; $display("FAIL bp_aw a0=%h l0=%0d a1=%h l1=%0d want 1f3c/12/2000/6", aw_q[0].addr, aw_q[0].len, aw_q[1].addr, aw_q[1].len); end
            n_vec++; if (aw_cyc[1] <= beat_cyc[12] || beat_cyc[13] <= aw_cyc[1]) begin n_err++; $display("FAIL bp_order aw1=%0d last0=%0d first1=%0d want last0<aw1<first1", aw_cyc[1], beat_cyc[12], beat_cyc[13]); end
            heads = 0;
            for (int i = 0; i < 20; i++) begin
                if (beat_q[i].isHead) heads++;
                n_vec++;
                if (beat_q[i].rmnBeat !== 8'((i < 13) ? 12 - i : 19 - i) || beat_q[i].lbN !== ((i < 13) ? 6'd32 : 6'd16)) begin
                    n_err++;
                    $display("FAIL bp_beat%0d rmn=%0d lbN=%0d want %0d/%0d", i, beat_q[i].rmnBeat, beat_q[i].lbN, (i < 13) ? 12 - i : 19 - i, (i < 13) ? 32 : 16);
                end
            end
            n_vec++; if (heads !== 2 || !beat_q[0].isHead || !beat_q[13].isHead) begin n_err++; $display("FAIL bp_heads got %0d want 2 at beats 0,13", heads); end
        end
    endtask

    task automatic test_zero_length();
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h500; req_nr_bytes = 32'd0;
        @(negedge clk);
        n_vec++; if (req_ready !== 1'b1 || aw_valid !== 1'b0 || txn_valid !== 1'b0) begin n_err++; $display("FAIL zero_dropped ready=%b awv=%b txv=%b want 1/0/0", req_ready, aw_valid, txn_valid); end
        req_addr = 64'h20; req_nr_bytes = 32'd16;
        @(negedge clk);
        req_valid = 1'b0;
        n_vec++; if (aw_valid !== 1'b1 || aw_addr !== 64'h20 || aw_len !== 8'd0) begin n_err++; $display("FAIL zero_next_aw awv=%b addr=%h len=%0d want 1/20/0", aw_valid, aw_addr, aw_len); end
        aw_ready = 1'b1; txn_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (txn_valid) seen++;
        end
        aw_ready = 1'b0; txn_ready = 1'b0;
        n_vec++; if (seen !== 1) begin n_err++; $display("FAIL zero_next_beats got %0d want 1", seen); end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 64'h1004; req_nr_bytes = 32'd40;
        aw_ready = 1'b1; txn_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (txn_valid !== 1'b1 || txn_ctrl.rmnBeat !== 8'd1) begin n_err++; $display("FAIL rst_pre_beat1 txv=%b rmn=%0d want 1/1", txn_valid, txn_ctrl.rmnBeat); end
        #2 rst_ni = 1'b0;
        #1;
        n_vec++; if (aw_valid !== 1'b0 || txn_valid !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL rst_immediate awv=%b txv=%b ready=%b want 0/0/1", aw_valid, txn_valid, req_ready); end
        @(negedge clk);
        rst_ni = 1'b1; aw_ready = 1'b0; txn_ready = 1'b0;
        run_req(64'h40, 32'd32, 0, 50);
        n_vec++; if (timed_out || aw_q.size() !== 1 || beat_q.size() !== 2) begin n_err++; $display("FAIL rst_restart_counts timeout=%b aw=%0d beats=%0d want 0/1/2", timed_out, aw_q.size(), beat_q.size()); end
        if (aw_q.size() == 1 && beat_q.size() == 2) begin
            n_vec++; if (aw_q[0].addr !== 64'h40 || aw_q[0].len !== 8'd1 || beat_q[0].isHead !== 1'b1 || beat_q[0].rmnBeat !== 8'd1) begin n_err++; $display("FAIL rst_restart addr=%h len=%0d head=%b rmn=%0d want 40/1/1/1", aw_q[0].addr, aw_q[0].len, beat_q[0].isHead, beat_q[0].rmnBeat); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_unaligned();
        test_4k_split();
        test_max_burst();
        test_backpressure();
        test_zero_length();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
